// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU writeback, load/IO handshake and register-file write port.
//   master : the pipeline side (drives ALU/load requests, observes the write port)
//   slave  : the arbiter (accepts requests, drives we3/wa3/wd3, pending, count)
interface wb_arbiter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             alu_we;
  logic [3:0]       alu_wa;
  logic [WIDTH-1:0] alu_wd;
  logic             ld_valid;
  logic             ld_ready;
  logic [3:0]       ld_wa;
  logic [WIDTH-1:0] ld_wd;
  logic             we3;
  logic [3:0]       wa3;
  logic [WIDTH-1:0] wd3;
  logic [15:0]      pending;
  logic [CW-1:0]    count;

  modport master (
    output alu_we, alu_wa, alu_wd, ld_valid, ld_wa, ld_wd,
    input  ld_ready, we3, wa3, wd3, pending, count
  );

  modport slave (
    input  alu_we, alu_wa, alu_wd, ld_valid, ld_wa, ld_wd,
    output ld_ready, we3, wa3, wd3, pending, count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the fixed-priority ALU writeback and a FIFO-buffered load
// stream onto the single register-file write port, and exports a pending-load mask.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : wb_arbiter_if.slave (ALU/load inputs, ld_ready, we3/wa3/wd3, pending, count)
module wb_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic          clk,
  input logic          reset,
  wb_arbiter_if.slave  bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [3:0]       wa_q [DEPTH];
  logic [WIDTH-1:0] wd_q [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [PW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [15:0]      pending_q, pending_d;
  logic             we3_q, we3_d;
  logic [3:0]       wa3_q, wa3_d;
  logic [WIDTH-1:0] wd3_q, wd3_d;
  logic             ld_ready;
  logic             alu_hit, pop, push;

  // Ready depends only on registered occupancy: no credit for a pop in the same cycle.
  assign ld_ready     = !reset && (count_q < CW'(DEPTH));
  assign bus.ld_ready = ld_ready;
  assign bus.we3      = we3_q;
  assign bus.wa3      = wa3_q;
  assign bus.wd3      = wd3_q;
  assign bus.pending  = pending_q;
  assign bus.count    = count_q;

  always_comb begin
    alu_hit = bus.alu_we && (bus.alu_wa != 4'd0);
    pop     = !alu_hit && (count_q != '0);
    // Loads to r0 complete the handshake but are dropped.
    push    = bus.ld_valid && ld_ready && (bus.ld_wa != 4'd0);

    live_d = live_q;
    // The ALU result is newer than any stored load to the same register.
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_hit && (wa_q[i] == bus.alu_wa)) live_d[i] = 1'b0;
    end
    if (pop) live_d[rd_q] = 1'b0;
    // A load accepted alongside the ALU write is newer still, so it goes in live.
    if (push) live_d[wr_q] = 1'b1;

    pending_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_d[i]) begin
        if (push && (PW'(i) == wr_q)) pending_d = pending_d | (16'd1 << bus.ld_wa);
        else                          pending_d = pending_d | (16'd1 << wa_q[i]);
      end
    end
    pending_d[0] = 1'b0;

    count_d = count_q + CW'(push) - CW'(pop);

    we3_d = 1'b0;
    wa3_d = wa3_q;
    wd3_d = wd3_q;
    if (alu_hit) begin
      we3_d = 1'b1;
      wa3_d = bus.alu_wa;
      wd3_d = bus.alu_wd;
    end else if (pop && live_q[rd_q]) begin
      we3_d = 1'b1;
      wa3_d = wa_q[rd_q];
      wd3_d = wd_q[rd_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_q    <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      count_q   <= '0;
      pending_q <= '0;
      we3_q     <= 1'b0;
      wa3_q     <= 4'd0;
      wd3_q     <= '0;
    end else begin
      live_q    <= live_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      we3_q     <= we3_d;
      wa3_q     <= wa3_d;
      wd3_q     <= wd3_d;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (push) wr_q <= wr_q + 1'b1;
    end
  end

  // Entry payload needs no reset; validity is tracked by live_q and count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      wa_q[wr_q] <= bus.ld_wa;
      wd_q[wr_q] <= bus.ld_wd;
    end
  end
endmodule
